// File: rtl/ex_stage.sv
// ex_stage -- execute stage of a 5-stage MIPS-style pipeline.
// Computes the ALU result, branch target and destination register, and
// registers them together with the WB/M control groups into EX/MEM.
// Optional feature: define EX_MUL_EN to build a 33-cycle iterative
// shift-add multiplier (funct 0x18) that stalls the upstream stages.
// Without EX_MUL_EN, funct 0x18 yields 0 in one cycle and stall is tied low.

`ifndef INTERNAL_BITS
`define INTERNAL_BITS 32
`endif

module ex_stage (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [3:0]                EX_in,
  input  logic [1:0]                WB_in,
  input  logic [2:0]                M_in,
  input  logic [`INTERNAL_BITS-1:0] Read_data1,
  input  logic [`INTERNAL_BITS-1:0] Read_data2,
  input  logic [`INTERNAL_BITS-1:0] Sign_extend,
  input  logic [`INTERNAL_BITS-1:0] PC,
  input  logic [4:0]                Instruction_20_16,
  input  logic [4:0]                Instruction_15_11,
  output logic [1:0]                WB_out,
  output logic [2:0]                M_out,
  output logic [`INTERNAL_BITS-1:0] ALU_result,
  output logic                      ALU_zero,
  output logic [`INTERNAL_BITS-1:0] Write_data,
  output logic [4:0]                Write_reg,
  output logic [`INTERNAL_BITS-1:0] Branch_target,
  output logic                      stall
);

  localparam int W = `INTERNAL_BITS;

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL, OP_NONE
  } alu_op_e;

  logic          reg_dst;
  logic [1:0]    alu_op;
  logic          alu_src;
  logic [5:0]    funct;
  logic [W-1:0]  op_b;
  logic [W-1:0]  branch_target;
  logic [4:0]    write_reg;
  logic [W-1:0]  alu_result;
  alu_op_e       op;

  assign {reg_dst, alu_op, alu_src} = EX_in;
  assign funct         = Sign_extend[5:0];
  assign op_b          = alu_src ? Sign_extend : Read_data2;
  assign branch_target = PC + (Sign_extend << 2);
  assign write_reg     = reg_dst ? Instruction_15_11 : Instruction_20_16;

  // Decode ALUOp (and funct for R-type) into one ALU operation.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path can leave it unassigned and infer a latch.
    op = OP_ADD;
    case (alu_op)
      2'b01: op = OP_SUB;
      2'b10: begin
        case (funct)
          6'h20:   op = OP_ADD;
          6'h22:   op = OP_SUB;
          6'h24:   op = OP_AND;
          6'h25:   op = OP_OR;
          6'h2A:   op = OP_SLT;
`ifdef EX_MUL_EN
          6'h18:   op = OP_MUL;
`endif
          default: op = OP_NONE;
        endcase
      end
      default: op = OP_ADD;
    endcase
  end

  // Single-cycle ALU; unsupported functs (and mult here) produce 0.
  always_comb begin
    alu_result = '0;
    case (op)
      OP_ADD:  alu_result = Read_data1 + op_b;
      OP_SUB:  alu_result = Read_data1 - op_b;
      OP_AND:  alu_result = Read_data1 & op_b;
      OP_OR:   alu_result = Read_data1 | op_b;
      OP_SLT:  alu_result = {{(W-1){1'b0}}, $signed(Read_data1) < $signed(op_b)};
      default: alu_result = '0;
    endcase
  end

`ifdef EX_MUL_EN
  typedef enum logic {IDLE, MUL} state_e;

  state_e        state_q;
  state_e        state_d;
  logic [4:0]    count_q;
  logic [W-1:0]  mcand_q;
  logic [W-1:0]  mplier_q;
  logic [W-1:0]  acc_q;
  logic [W-1:0]  acc_next;
  logic [1:0]    wb_q;
  logic [2:0]    m_q;
  logic [4:0]    wr_q;
  logic          mul_start;
  logic          mul_done;

  // One shift-add step: add the multiplicand shifted to the current bit.
  assign acc_next = acc_q + (mplier_q[count_q] ? (mcand_q << count_q) : '0);

  // FSM next state and stall; flush and rst abort and mask stall.
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    mul_start = 1'b0;
    mul_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (op == OP_MUL && !flush) begin
          stall     = 1'b1;
          mul_start = 1'b1;
          state_d   = MUL;
        end
      end
      MUL: begin
        stall = !flush;
        if (count_q == 5'd31) begin
          mul_done = !flush;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
    if (rst) begin
      stall     = 1'b0;
      mul_start = 1'b0;
      mul_done  = 1'b0;
      state_d   = IDLE;
    end
  end

  // State register and iteration counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (mul_start)             count_q <= '0;
      else if (state_q == MUL)   count_q <= count_q + 5'd1;
    end
  end

  // Operand capture on MUL entry and accumulator update while in MUL.
  always_ff @(posedge clk) begin
    // NOTE: these datapath registers are deliberately not reset; they are
    // always written at MUL entry before being read.
    if (mul_start) begin
      mcand_q  <= Read_data1;
      mplier_q <= op_b;
      acc_q    <= '0;
      wb_q     <= WB_in;
      m_q      <= M_in;
      wr_q     <= write_reg;
    end else if (state_q == MUL) begin
      acc_q <= acc_next;
    end
  end
`else
  assign stall = 1'b0;
`endif

  // EX/MEM output register: reset > flush bubble > multiply > normal load.
  always_ff @(posedge clk) begin
    if (rst) begin
      WB_out        <= '0;
      M_out         <= '0;
      ALU_result    <= '0;
      ALU_zero      <= 1'b0;
      Write_data    <= '0;
      Write_reg     <= '0;
      Branch_target <= '0;
    end else if (flush) begin
      WB_out <= '0;
      M_out  <= '0;
`ifdef EX_MUL_EN
    end else if (mul_start) begin
      WB_out <= '0;
      M_out  <= '0;
    end else if (state_q == MUL) begin
      if (mul_done) begin
        ALU_result <= acc_next;
        ALU_zero   <= (acc_next == '0);
        WB_out     <= wb_q;
        M_out      <= m_q;
        Write_reg  <= wr_q;
      end
`endif
    end else begin
      WB_out        <= WB_in;
      M_out         <= M_in;
      ALU_result    <= alu_result;
      ALU_zero      <= (alu_result == '0);
      Write_data    <= Read_data2;
      Write_reg     <= write_reg;
      Branch_target <= branch_target;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage -- self-checking bench for ex_stage (either EX_MUL_EN build).
// A transaction-level model predicts EX/MEM contents and stall every cycle;
// directed cases pin the model with hand-computed literals.
`timescale 1ns/1ps

module tb_ex_stage;

`ifdef EX_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [3:0]  EX_in;
  logic [1:0]  WB_in;
  logic [2:0]  M_in;
  logic [31:0] Read_data1, Read_data2, Sign_extend, PC;
  logic [4:0]  Instruction_20_16, Instruction_15_11;
  logic [1:0]  WB_out;
  logic [2:0]  M_out;
  logic [31:0] ALU_result, Write_data, Branch_target;
  logic        ALU_zero;
  logic [4:0]  Write_reg;
  logic        stall;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .EX_in(EX_in), .WB_in(WB_in), .M_in(M_in),
    .Read_data1(Read_data1), .Read_data2(Read_data2),
    .Sign_extend(Sign_extend), .PC(PC),
    .Instruction_20_16(Instruction_20_16), .Instruction_15_11(Instruction_15_11),
    .WB_out(WB_out), .M_out(M_out), .ALU_result(ALU_result), .ALU_zero(ALU_zero),
    .Write_data(Write_data), .Write_reg(Write_reg),
    .Branch_target(Branch_target), .stall(stall)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid = 1'b0;
  bit          m_busy  = 1'b0;
  int          m_left;
  logic [31:0] e_res, e_wd, e_bt;
  logic        e_zero;
  logic [1:0]  e_wb;
  logic [2:0]  e_m;
  logic [4:0]  e_wr;
  logic [31:0] p_prod;
  logic [1:0]  p_wb;
  logic [2:0]  p_m;
  logic [4:0]  p_wr;

  function automatic logic [31:0] opb();
    return EX_in[0] ? Sign_extend : Read_data2;
  endfunction

  function automatic bit is_mult();
    return (EX_in[2:1] == 2'b10) && (Sign_extend[5:0] == 6'h18);
  endfunction

  function automatic logic [31:0] alu_ref();
    logic [31:0] a, b;
    a = Read_data1;
    b = opb();
    if (EX_in[2:1] == 2'b01) return a - b;
    if (EX_in[2:1] != 2'b10) return a + b;
    case (Sign_extend[5:0])
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h2A:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [31:0] r;
    if (rst) begin
      m_valid = 1'b1; m_busy = 1'b0;
      e_res = 0; e_wd = 0; e_bt = 0; e_zero = 0; e_wb = 0; e_m = 0; e_wr = 0;
    end else if (flush) begin
      m_busy = 1'b0; e_wb = 0; e_m = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        e_res = p_prod; e_zero = (p_prod == 0);
        e_wb = p_wb; e_m = p_m; e_wr = p_wr;
      end
    end else if (MUL_EN && is_mult()) begin
      m_busy = 1'b1; m_left = 32;
      p_prod = Read_data1 * opb();
      p_wb = WB_in; p_m = M_in;
      p_wr = EX_in[3] ? Instruction_15_11 : Instruction_20_16;
      e_wb = 0; e_m = 0;
    end else begin
      r = alu_ref();
      e_res = r; e_zero = (r == 0);
      e_wb = WB_in; e_m = M_in;
      e_wr = EX_in[3] ? Instruction_15_11 : Instruction_20_16;
      e_wd = Read_data2;
      e_bt = PC + (Sign_extend << 2);
    end
  end

  // Compare process: every falling edge once the model is initialised.
  always @(negedge clk) begin
    if (m_valid) begin
      check("WB_out",        WB_out,        e_wb);
      check("M_out",         M_out,         e_m);
      check("ALU_result",    ALU_result,    e_res);
      check("ALU_zero",      ALU_zero,      e_zero);
      check("Write_data",    Write_data,    e_wd);
      check("Write_reg",     Write_reg,     e_wr);
      check("Branch_target", Branch_target, e_bt);
      check("stall", stall, MUL_EN && !rst && !flush && (m_busy || is_mult()));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input logic [1:0] aluop, input logic alusrc, input logic regdst,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] se,
                        input logic [31:0] pc, input logic [1:0] wb, input logic [2:0] m,
                        input logic [4:0] rt, input logic [4:0] rd);
    EX_in = {regdst, aluop, alusrc};
    Read_data1 = a; Read_data2 = b; Sign_extend = se; PC = pc;
    WB_in = wb; M_in = m; Instruction_20_16 = rt; Instruction_15_11 = rd;
  endtask

  task automatic rand_op();
    logic [31:0] se, a, b;
    logic [5:0]  f;
    logic [1:0]  aluop;
    aluop = 2'($urandom_range(0, 3));
    case ($urandom_range(0, 6))
      0: f = 6'h20; 1: f = 6'h22; 2: f = 6'h24; 3: f = 6'h25;
      4: f = 6'h2A; 5: f = 6'h18; default: f = 6'($urandom());
    endcase
    se = $urandom();
    if (aluop == 2'b10) se[5:0] = f;
    a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom();
    b = ($urandom_range(0, 3) == 0) ? a : $urandom();
    set_op(aluop, 1'($urandom_range(0, 3) == 0), 1'($urandom()), a, b, se, $urandom(),
           2'($urandom()), 3'($urandom()), 5'($urandom()), 5'($urandom()));
  endtask

  int stall_cycles, bubbles;

  initial begin
    rst = 1'b1; flush = 1'b0;
    set_op(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(); cycle();
    // reset state
    check("rst_alu_result", ALU_result, 32'd0);
    check("rst_alu_zero",   ALU_zero,   32'd0);
    check("rst_wb",         WB_out,     32'd0);
    check("rst_stall",      stall,      32'd0);
    rst = 1'b0;

    // R-type add 5+7
    set_op(2'b10, 0, 1, 32'd5, 32'd7, 32'h20, 32'h40, 2'b10, 3'b000, 5'd3, 5'd9);
    #1 check("add_stall", stall, 32'd0);
    cycle();
    check("add_result", ALU_result, 32'd12);
    check("add_zero",   ALU_zero,   32'd0);
    check("add_wreg",   Write_reg,  32'd9);

    // beq-style subtract, branch target
    set_op(2'b01, 0, 0, 32'h1234, 32'h1234, 32'd3, 32'h100, 2'b00, 3'b100, 5'd4, 5'd8);
    cycle();
    check("beq_zero",   ALU_zero,      32'd1);
    check("beq_target", Branch_target, 32'h10C);
    check("beq_wreg",   Write_reg,     32'd4);

    // signed slt -1 < 1
    set_op(2'b10, 0, 1, 32'hFFFF_FFFF, 32'd1, 32'h2A, 32'h0, 2'b10, 3'b000, 5'd1, 5'd2);
    cycle();
    check("slt_result", ALU_result, 32'd1);

    // immediate add with wrap-around to zero
    set_op(2'b00, 1, 0, 32'hFFFF_FFFF, 32'd99, 32'd1, 32'h0, 2'b11, 3'b010, 5'd6, 5'd7);
    cycle();
    check("wrap_result", ALU_result, 32'd0);
    check("wrap_zero",   ALU_zero,   32'd1);
    check("wrap_wdata",  Write_data, 32'd99);

`ifdef EX_MUL_EN
    // mult 0x00010003 * 5, with inputs disturbed mid-multiply
    set_op(2'b10, 0, 1, 32'h0001_0003, 32'd5, 32'h18, 32'h0, 2'b11, 3'b001, 5'd2, 5'd17);
    stall_cycles = 0; bubbles = 0;
    for (int k = 0; k < 33; k++) begin
      if (k == 5) Read_data1 = 32'hDEAD_BEEF;
      #1 if (stall === 1'b1) stall_cycles++;
      cycle();
      if (k < 32 && WB_out == 2'b00 && M_out == 3'b000) bubbles++;
    end
    check("mul_stall_cycles", stall_cycles, 32'd33);
    check("mul_bubbles",      bubbles,      32'd32);
    check("mul_result",       ALU_result,   32'h0005_000F);
    check("mul_wb",           WB_out,       32'd3);
    check("mul_wreg",         Write_reg,    32'd17);
    set_op(2'b00, 0, 0, 32'd1, 32'd2, 32'd0, 32'h0, 2'b01, 3'b000, 5'd5, 5'd6);
    #1 check("mul_after_stall", stall, 32'd0);

    // flush at MUL cycle 10
    set_op(2'b10, 0, 1, 32'd9, 32'd9, 32'h18, 32'h0, 2'b11, 3'b011, 5'd2, 5'd17);
    cycle();
    for (int k = 0; k < 10; k++) cycle();
    flush = 1'b1;
    #1 check("flush_stall", stall, 32'd0);
    cycle();
    check("flush_wb", WB_out, 32'd0);
    check("flush_m",  M_out,  32'd0);
    flush = 1'b0;
    set_op(2'b00, 0, 0, 32'd20, 32'd22, 32'd0, 32'h0, 2'b01, 3'b000, 5'd5, 5'd6);
    #1 check("flush_idle_stall", stall, 32'd0);
    cycle();
    check("flush_next_add", ALU_result, 32'd42);
    check("flush_next_wb",  WB_out,     32'd1);

    // flush in the same cycle as a mult decode
    set_op(2'b10, 0, 1, 32'd3, 32'd3, 32'h18, 32'h0, 2'b11, 3'b011, 5'd2, 5'd17);
    flush = 1'b1;
    #1 check("flush_dec_stall", stall, 32'd0);
    cycle();
    flush = 1'b0;
    set_op(2'b00, 0, 0, 32'd4, 32'd4, 32'd0, 32'h0, 2'b10, 3'b000, 5'd5, 5'd6);
    #1 check("flush_dec_idle", stall, 32'd0);
    cycle();
    check("flush_dec_add", ALU_result, 32'd8);
`else
    // mult unsupported: zero result, no stall
    set_op(2'b10, 0, 1, 32'h0001_0003, 32'd5, 32'h18, 32'h0, 2'b11, 3'b001, 5'd2, 5'd17);
    #1 check("nomul_stall", stall, 32'd0);
    cycle();
    check("nomul_result", ALU_result, 32'd0);
    check("nomul_zero",   ALU_zero,   32'd1);
    check("nomul_wb",     WB_out,     32'd3);
    check("nomul_stall2", stall,      32'd0);
`endif

    // rst while a mult is (or would be) in progress
    set_op(2'b10, 0, 1, 32'd7, 32'd6, 32'h18, 32'h0, 2'b11, 3'b111, 5'd2, 5'd17);
    for (int k = 0; k < 6; k++) cycle();
    rst = 1'b1;
    #1 check("rst_mid_stall", stall, 32'd0);
    cycle();
    check("rst_mid_result", ALU_result,    32'd0);
    check("rst_mid_zero",   ALU_zero,      32'd0);
    check("rst_mid_wb",     WB_out,        32'd0);
    check("rst_mid_m",      M_out,         32'd0);
    check("rst_mid_wreg",   Write_reg,     32'd0);
    check("rst_mid_target", Branch_target, 32'd0);
    rst = 1'b0;
    set_op(2'b00, 0, 0, 32'd30, 32'd12, 32'd0, 32'h0, 2'b01, 3'b000, 5'd5, 5'd6);
    cycle();
    check("rst_next_add", ALU_result, 32'd42);

    // randomized traffic; upstream normally holds inputs while stalled
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 49) == 0);
      if (!stall || $urandom_range(0, 9) == 0) rand_op();
      cycle();
    end
    rst = 1'b0; flush = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port flush  input  1  synchronous squash of the instruction in EX.
REQ-004 SHALL have inputs EX_in[3:0] {RegDst, ALUOp1, ALUOp0, ALUSrc}, WB_in[1:0] {RegWrite, MemToReg} and M_in[2:0] {Branch, MemRead, MemWrite}, all from the ID/EX register.
REQ-005 SHALL have inputs Read_data1, Read_data2, Sign_extend and PC, each `INTERNAL_BITS (32) wide.
REQ-006 SHALL have inputs Instruction_20_16[4:0] and Instruction_15_11[4:0].
REQ-007 SHALL have registered outputs WB_out[1:0], M_out[2:0], ALU_result[31:0], ALU_zero, Write_data[31:0], Write_reg[4:0] and Branch_target[31:0], all feeding EX/MEM.
REQ-008 SHALL have output stall (1 bit, combinational); while high, upstream holds PC, IF/ID and ID/EX.

Function
REQ-009 SHALL select operand B as Sign_extend when ALUSrc=1, otherwise Read_data2.
REQ-010 SHALL decode ALUOp as follows: 00 add; 01 sub; 10 R-type decoded from funct = Sign_extend[5:0]; 11 add.
REQ-011 SHALL decode R-type funct as: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A signed slt (result 1/0), 0x18 mult; any other funct gives result 0.
REQ-012 SHALL perform add and sub modulo 2^32 with no overflow trap.
REQ-013 SHALL compute Branch_target = PC + (Sign_extend << 2), modulo 2^32.
REQ-014 SHALL compute Write_reg = RegDst ? Instruction_15_11 : Instruction_20_16, and Write_data = Read_data2.
REQ-015 SHALL compute ALU_zero = (ALU_result == 0), taken from the same registered result.
REQ-016 SHALL register single-cycle ops into the outputs at the first rising edge, so latency is 1 cycle and stall stays 0.
REQ-017 SHALL implement an FSM with states IDLE and MUL; reset state is IDLE.
REQ-018 SHALL, in IDLE with mult decoded and flush=0: assert stall; at the edge, latch operands, clear the accumulator, set the 5-bit count to 0, enter MUL, and load a bubble into the outputs.
REQ-019 SHALL, in MUL: hold stall=1 and do one shift-add iteration per cycle on multiplier bit [count].
REQ-020 SHALL, at the edge where count=31: load the low 32 bits of the product plus the latched WB, M and Write_reg values into the outputs, and return to IDLE.
REQ-021 SHALL take 33 cycles in total for mult (1 IDLE + 32 MUL), with the result visible after the 33rd edge.
REQ-022 SHALL mean by "bubble" WB_out=0 and M_out=0, with data outputs don't-care but deterministic (held).
REQ-023 SHALL, when flush=1 at an edge, load a bubble into the outputs and force state IDLE, aborting any multiply in progress.
REQ-024 SHALL mask stall to 0 while flush=1.
REQ-025 SHALL give flush priority over a mult decode in the same cycle, so MUL is not entered.
REQ-026 SHALL, while in MUL, ignore changes on the ID/EX inputs; the operands were latched on MUL entry.

Reset
REQ-027 SHALL, on rst=1 at an edge: set state to IDLE and count to 0, and set every output register (WB_out, M_out, ALU_result, ALU_zero, Write_data, Write_reg, Branch_target) to 0.
REQ-028 SHALL drive stall to 0 while rst=1.
REQ-029 SHALL give rst priority over flush, and SHALL abort an in-progress multiply when rst is asserted mid-MUL.

Configuration
REQ-030 SHALL, with macro EX_MUL_EN defined, build the iterative multiplier, the MUL state and the stall logic as specified above.
REQ-031 SHALL, with EX_MUL_EN undefined, treat funct 0x18 as unsupported (result 0, 1-cycle latency), tie stall to 0, and build no MUL state or multiplier datapath.

Verification
REQ-032 SHALL cover: R-type add with Read_data1=5, Read_data2=7, funct 0x20 -> ALU_result=12 and ALU_zero=0 one edge later, stall=0.
REQ-033 SHALL cover: beq-style ALUOp=01 with Read_data1=Read_data2=0x1234 -> ALU_zero=1; with PC=0x100 and Sign_extend=3 -> Branch_target=0x10C.
REQ-034 SHALL cover: slt with Read_data1=0xFFFFFFFF and Read_data2=1 -> ALU_result=1.
REQ-035 SHALL cover (EX_MUL_EN defined): mult of 0x0001_0003 by 0x0000_0005 -> stall high for 33 cycles, 32 bubbles out, then ALU_result=0x0005_000F and WB_out=WB_in as captured.
REQ-036 SHALL cover: flush asserted at MUL cycle 10 -> bubble out at the next edge, stall=0, state IDLE, and the next add completes normally.
REQ-037 SHALL cover: rst asserted mid-MUL, and a build with EX_MUL_EN undefined running mult -> all outputs 0 after reset; in the undefined build, mult gives ALU_result=0 with stall never asserted.
